// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a per-entry saturating direction
// counter, plus a saturating mispredict statistics counter.
module branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 64,
  parameter int CTR_WIDTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clrCount,
  input  logic [ADDR_WIDTH-1:0] pcF,
  output logic                  hitF,
  output logic                  predictTakenF,
  output logic [ADDR_WIDTH-1:0] predictTargetF,
  input  logic                  updateE,
  input  logic [ADDR_WIDTH-1:0] pcE,
  input  logic                  takenE,
  input  logic [ADDR_WIDTH-1:0] targetE,
  input  logic                  predictedTakenE,
  input  logic [ADDR_WIDTH-1:0] predictedTargetE,
  output logic                  mispredictE,
  output logic [CNT_WIDTH-1:0]  mispredictCount
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  localparam logic [CTR_WIDTH-1:0] CTR_WT  = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WT - CTR_WIDTH'(1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_MIN = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [CTR_WIDTH-1:0]  ctr_q    [ENTRIES];

  logic [IDX-1:0]        idx_f, idx_e;
  logic [TAG_W-1:0]      tag_f, tag_e;
  logic                  hit_e;
  logic                  upd_fire;
  logic                  wr_en;
  logic [CTR_WIDTH-1:0]  ctr_cur;
  logic [CTR_WIDTH-1:0]  nxt_ctr;
  logic [ADDR_WIDTH-1:0] nxt_target;

  // Word-aligned PCs: the two low bits never take part in indexing or tagging.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{pcF[1:0], pcE[1:0]};

  assign idx_f = pcF[IDX+1:2];
  assign tag_f = pcF[ADDR_WIDTH-1:IDX+2];
  assign idx_e = pcE[IDX+1:2];
  assign tag_e = pcE[ADDR_WIDTH-1:IDX+2];

  assign hitF           = en & valid_q[idx_f] & (tag_q[idx_f] == tag_f);
  assign predictTakenF  = hitF & ctr_q[idx_f][CTR_WIDTH-1];
  assign predictTargetF = predictTakenF ? target_q[idx_f] : pcF + ADDR_WIDTH'(4);

  assign mispredictE = updateE & en &
                       ((takenE != predictedTakenE) |
                        (takenE & (targetE != predictedTargetE)));

  assign upd_fire = updateE & en;
  assign hit_e    = valid_q[idx_e] & (tag_q[idx_e] == tag_e);
  assign ctr_cur  = ctr_q[idx_e];

  always_comb begin
    wr_en      = 1'b0;
    nxt_ctr    = ctr_cur;
    nxt_target = target_q[idx_e];
    if (upd_fire) begin
      if (hit_e) begin
        wr_en = 1'b1;
        if (takenE) begin
          nxt_target = targetE;
          if (ctr_cur != CTR_MAX) nxt_ctr = ctr_cur + CTR_WIDTH'(1);
        end else if (ctr_cur != CTR_MIN) begin
          nxt_ctr = ctr_cur - CTR_WIDTH'(1);
        end
      end else if (takenE) begin
        // Allocation replaces whatever entry currently aliases this index.
        wr_en      = 1'b1;
        nxt_ctr    = CTR_WT;
        nxt_target = targetE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid_q[idx_e]  <= 1'b1;
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= nxt_target;
      ctr_q[idx_e]    <= nxt_ctr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredictCount <= '0;
    end else if (clrCount) begin
      mispredictCount <= '0;
    end else if (mispredictE && (mispredictCount != CNT_MAX)) begin
      mispredictCount <= mispredictCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver pushes expected outputs from
// a table-level reference model, a negedge monitor pops and compares them.
module tb_branch_predictor;
  localparam int AW   = 32;
  localparam int NENT = 64;
  localparam int CW   = 2;
  localparam int NW   = 4;
  localparam int CMAX = 3;
  localparam int KMAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          clrCount;
  logic [AW-1:0] pcF;
  logic          hitF;
  logic          predictTakenF;
  logic [AW-1:0] predictTargetF;
  logic          updateE;
  logic [AW-1:0] pcE;
  logic          takenE;
  logic [AW-1:0] targetE;
  logic          predictedTakenE;
  logic [AW-1:0] predictedTargetE;
  logic          mispredictE;
  logic [NW-1:0] mispredictCount;

  branch_predictor #(.ADDR_WIDTH(AW), .ENTRIES(NENT), .CTR_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .en(en), .clrCount(clrCount), .pcF(pcF),
    .hitF(hitF), .predictTakenF(predictTakenF), .predictTargetF(predictTargetF),
    .updateE(updateE), .pcE(pcE), .takenE(takenE), .targetE(targetE),
    .predictedTakenE(predictedTakenE), .predictedTargetE(predictedTargetE),
    .mispredictE(mispredictE), .mispredictCount(mispredictCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        hit;
    logic        tk;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  bit          m_valid [NENT];
  int unsigned m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];
  int          m_cnt;

  function automatic int unsigned midx(logic [31:0] pc);
    return (pc >> 2) % NENT;
  endfunction

  function automatic int unsigned mtag(logic [31:0] pc);
    return pc >> (2 + $clog2(NENT));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
    end
    m_cnt = 0;
  endtask

  task automatic mlook(input logic [31:0] pc, input bit e, output bit h,
                       output bit tk, output logic [31:0] tgt);
    int unsigned i;
    i   = midx(pc);
    h   = e && m_valid[i] && (m_tag[i] == mtag(pc));
    tk  = h && (m_ctr[i] >= 2);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, c, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("hitF",            e.cyc, 32'(hitF),            32'(e.hit));
      chk("predictTakenF",   e.cyc, 32'(predictTakenF),   32'(e.tk));
      chk("predictTargetF",  e.cyc, predictTargetF,       e.tgt);
      chk("mispredictE",     e.cyc, 32'(mispredictE),     32'(e.mis));
      chk("mispredictCount", e.cyc, 32'(mispredictCount), e.cnt);
    end
  end

  task automatic push_exp(input logic [31:0] pf, input bit e, input bit mis);
    exp_t x;
    bit h, tk;
    logic [31:0] tg;
    mlook(pf, e, h, tk, tg);
    x.cyc = cyc; x.hit = h; x.tk = tk; x.tgt = tg; x.mis = mis; x.cnt = 32'(m_cnt);
    sb.push_back(x);
  endtask

  task automatic step(input bit e, input bit upd, input logic [31:0] pe, input bit tk,
                      input logic [31:0] te, input bit ptk, input logic [31:0] pte,
                      input logic [31:0] pf, input bit clr);
    bit mis, h;
    int unsigned i;
    @(posedge clk); #1;
    cyc++;
    en = e; updateE = upd; pcE = pe; takenE = tk; targetE = te;
    predictedTakenE = ptk; predictedTargetE = pte; pcF = pf; clrCount = clr;
    mis = upd && e && ((tk != ptk) || (tk && (te != pte)));
    push_exp(pf, e, mis);
    if (clr) m_cnt = 0;
    else if (mis && m_cnt < KMAX) m_cnt++;
    if (upd && e) begin
      i = midx(pe);
      h = m_valid[i] && (m_tag[i] == mtag(pe));
      if (h) begin
        if (tk) begin
          m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
          m_tgt[i] = te;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (tk) begin
        m_valid[i] = 1'b1; m_tag[i] = mtag(pe); m_tgt[i] = te; m_ctr[i] = 2;
      end
    end
  endtask

  // Update carrying the prediction the front end would have made for pe.
  task automatic upd_carry(input logic [31:0] pe, input bit tk, input logic [31:0] te,
                           input logic [31:0] pf);
    bit h, ptk;
    logic [31:0] pte;
    mlook(pe, 1'b1, h, ptk, pte);
    step(1'b1, 1'b1, pe, tk, te, ptk, pte, pf, 1'b0);
  endtask

  task automatic idle(input logic [31:0] pf);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, pf, 1'b0);
  endtask

  task automatic pulse_reset(input logic [31:0] pf);
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    en = 1'b1; clrCount = 1'b0; pcF = pf;
    updateE = 1'b1; pcE = 32'h300; takenE = 1'b1; targetE = 32'h500;
    predictedTakenE = 1'b1; predictedTargetE = 32'h500;
    model_reset();
    push_exp(pf, 1'b1, 1'b0);
    @(negedge clk); #1;
    updateE = 1'b0;
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rpc();
    case ($urandom_range(0, 5))
      0: return 32'h100;
      1: return 32'h200;
      2: return 32'h300;
      3: return 32'h104;
      4: return 32'h1100;
      default: return 32'($urandom_range(0, 1023)) << 2;
    endcase
  endfunction

  initial begin
    rst = 1'b0; en = 1'b1; clrCount = 1'b0; pcF = 32'h100;
    updateE = 1'b0; pcE = '0; takenE = 1'b0; targetE = '0;
    predictedTakenE = 1'b0; predictedTargetE = '0;
    model_reset();
    #2;
    push_exp(32'h100, 1'b1, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;

    // allocation, then hysteresis on 0x100 with lookup of the same PC each cycle
    upd_carry(32'h100, 1'b1, 32'h080, 32'h100);
    idle(32'h100);
    upd_carry(32'h100, 1'b1, 32'h080, 32'h100);
    upd_carry(32'h100, 1'b1, 32'h080, 32'h100);
    upd_carry(32'h100, 1'b0, 32'h000, 32'h100);
    upd_carry(32'h100, 1'b0, 32'h000, 32'h100);
    upd_carry(32'h100, 1'b0, 32'h000, 32'h100);
    upd_carry(32'h100, 1'b1, 32'h080, 32'h100);
    upd_carry(32'h100, 1'b1, 32'h080, 32'h100);
    idle(32'h100);

    // aliasing on index 0
    upd_carry(32'h200, 1'b1, 32'h240, 32'h100);
    idle(32'h100);
    idle(32'h200);

    // mispredict counter saturation and clear priority
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h400, 1'b1);
    for (int k = 0; k < 20; k++)
      step(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h404, 32'h400, 1'b0);
    step(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h404, 32'h400, 1'b1);
    idle(32'h400);
    idle(32'h400);

    // reset mid-run after allocating at 0x100
    upd_carry(32'h100, 1'b1, 32'h080, 32'h100);
    upd_carry(32'h100, 1'b0, 32'h000, 32'h100);
    idle(32'h100);
    pulse_reset(32'h100);
    idle(32'h100);
    idle(32'h300);

    // disabled predictor, then same-cycle lookup/update conflict
    step(1'b0, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304, 32'h300, 1'b0);
    idle(32'h300);
    upd_carry(32'h100, 1'b1, 32'h080, 32'h100);
    idle(32'h100);
    upd_carry(32'h100, 1'b1, 32'h0C0, 32'h100);
    idle(32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b0);

    // randomized traffic over a small PC pool so hits, aliases and saturation recur
    for (int k = 0; k < 400; k++) begin
      logic [31:0] pe, te, pte, pf;
      bit e, upd, tk, ptk, clr, h;
      pe  = rpc();
      pf  = rpc();
      te  = 32'($urandom_range(0, 255)) << 2;
      tk  = 1'($urandom_range(0, 1));
      e   = ($urandom_range(0, 9) != 0);
      upd = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 9) < 7) mlook(pe, 1'b1, h, ptk, pte);
      else begin
        ptk = 1'($urandom_range(0, 1));
        pte = 32'($urandom_range(0, 255)) << 2;
      end
      step(e, upd, pe, tk, te, ptk, pte, pf, clr);
    end

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
